apo_node_interface: RTL and testbench

- Compute-node side of the circulant-router injection/ejection port. It is the transmitter that drives a router's `in_free` input and the receiver of that router's `out_data` delivery pulse.
- Host requests are queued in a small FIFO and formatted into router injection words. Injection is paced so that a packet already in flight is not overrun at the router's input priority mux.
- Delivered packets are counted.
- One instance is placed per router node.

---
 rtl/apo_node_interface.sv | 137 +++++++++++++
 tb/tb_apo_node_interface.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apo_node_interface.sv
// Compute-node port of a circulant router: queues host send requests, injects
// them into the router paced by a fixed idle gap, and counts deliveries.
module apo_node_interface #(
   parameter int K          = 3,
   parameter int N2         = 7,
   parameter int NODE_COUNT = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int INJ_GAP    = 4,
   parameter int CNT_W      = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [K-1:0]                    router_name,
   input  logic                            send_valid,
   output logic                            send_ready,
   input  logic [K-1:0]                    send_dest,
   output logic [N2-1:0]                   to_router,
   input  logic                            from_router_data,
   output logic                            rx_pulse,
   output logic                            tx_busy,
   output logic                            self_send,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic [CNT_W-1:0]                tx_count,
   output logic [CNT_W-1:0]                rx_count,
   output logic [CNT_W-1:0]                drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int GW = (INJ_GAP < 2) ? 1 : $clog2(INJ_GAP);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_INJECT = 2'd1;
   localparam logic [1:0] ST_GAP    = 2'd2;

   logic [1:0]    state;
   logic [GW-1:0] gap_cnt;
   logic [K-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          empty;
   logic          accept;
   logic          dest_ok;
   logic          push;
   logic          pop;
   logic [K-1:0]  head;
   logic [N2-1:0] inj_word;

   // Handshake: a request transfers on any edge where send_valid && send_ready;
   // send_ready comes only from registered occupancy, never from this cycle's pop.
   always_comb begin
      full       = (fifo_level == LW'(FIFO_DEPTH));
      empty      = (fifo_level == '0);
      send_ready = !full;
      accept     = send_valid && send_ready;
      dest_ok    = (32'(send_dest) < NODE_COUNT);
      push       = accept && dest_ok;
      pop        = (state == ST_IDLE) && !empty;
      head       = mem[rd_ptr];
      inj_word            = '0;
      inj_word[N2-1]      = 1'b1;
      inj_word[K-1:0]     = head;
      tx_busy    = (state != ST_IDLE) || !empty;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= send_dest;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // to_router and self_send are registered on the pop edge, so they are
   // high for exactly the one INJECT cycle and zero everywhere else.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         gap_cnt   <= '0;
         to_router <= '0;
         self_send <= 1'b0;
         tx_count  <= '0;
      end else begin
         to_router <= '0;
         self_send <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  to_router <= inj_word;
                  self_send <= (head == router_name);
                  state     <= ST_INJECT;
               end
            end
            ST_INJECT: begin
               if (tx_count != '1) tx_count <= tx_count + CNT_W'(1);
               if (INJ_GAP == 0) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= GW'(INJ_GAP - 1);
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) state <= ST_IDLE;
               else               gap_cnt <= gap_cnt - GW'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_pulse   <= 1'b0;
         rx_count   <= '0;
         drop_count <= '0;
      end else begin
         rx_pulse <= from_router_data;
         if (from_router_data && (rx_count != '1)) rx_count <= rx_count + CNT_W'(1);
         if (accept && !dest_ok && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_apo_node_interface.sv
// Bench for apo_node_interface: a queue/time-based model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_apo_node_interface;

   localparam int K          = 3;
   localparam int N2         = 7;
   localparam int NODE_COUNT = 5;
   localparam int FIFO_DEPTH = 4;
   localparam int INJ_GAP    = 4;
   localparam int CNT_W      = 8;
   localparam int LW         = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [K-1:0]      router_name = '0;
   logic              send_valid = 1'b0;
   logic              send_ready;
   logic [K-1:0]      send_dest = '0;
   logic [N2-1:0]     to_router;
   logic              from_router_data = 1'b0;
   logic              rx_pulse;
   logic              tx_busy;
   logic              self_send;
   logic [LW-1:0]     fifo_level;
   logic [CNT_W-1:0]  tx_count;
   logic [CNT_W-1:0]  rx_count;
   logic [CNT_W-1:0]  drop_count;

   apo_node_interface #(
      .K(K), .N2(N2), .NODE_COUNT(NODE_COUNT), .FIFO_DEPTH(FIFO_DEPTH),
      .INJ_GAP(INJ_GAP), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .router_name(router_name),
      .send_valid(send_valid), .send_ready(send_ready), .send_dest(send_dest),
      .to_router(to_router), .from_router_data(from_router_data),
      .rx_pulse(rx_pulse), .tx_busy(tx_busy), .self_send(self_send),
      .fifo_level(fifo_level), .tx_count(tx_count), .rx_count(rx_count),
      .drop_count(drop_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   bit chk_en = 1'b0;

   // model: pending destinations and the cycle of the most recent injection
   logic [K-1:0] exp_q[$];
   int           m_last_inj = -1000;
   int           m_to_router = 0;
   int           m_self = 0;
   int           m_tx = 0;
   int           m_rx = 0;
   int           m_drop = 0;
   int           m_rx_pulse = 0;
   int           m_lvl;
   int           m_d;

   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_last_inj  = -1000;
         m_to_router = 0;
         m_self      = 0;
         m_tx        = 0;
         m_rx        = 0;
         m_drop      = 0;
         m_rx_pulse  = 0;
      end else begin
         m_lvl = exp_q.size();
         if (cyc == m_last_inj && m_tx < CNT_MAX) m_tx++;
         m_to_router = 0;
         m_self      = 0;
         // the next packet may leave once the previous one plus its gap are over
         if (m_lvl > 0 && cyc >= m_last_inj + INJ_GAP + 1) begin
            m_d         = int'(exp_q.pop_front());
            m_to_router = (1 << (N2 - 1)) + m_d;
            m_self      = (m_d == int'(router_name)) ? 1 : 0;
            m_last_inj  = cyc + 1;
         end
         if (send_valid && m_lvl < FIFO_DEPTH) begin
            if (int'(send_dest) >= NODE_COUNT) begin
               if (m_drop < CNT_MAX) m_drop++;
            end else begin
               exp_q.push_back(send_dest);
            end
         end
         m_rx_pulse = from_router_data ? 1 : 0;
         if (from_router_data && m_rx < CNT_MAX) m_rx++;
      end
      cyc++;
   end

   // scoreboard: per-cycle compare plus directed checks posted by the driver
   typedef struct {
      string       nm;
      logic [31:0] act;
      logic [31:0] exp;
   } dchk_t;

   dchk_t dq[$];
   int    checks = 0;
   int    failures = 0;
   int    inj_log[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("to_router",  32'(to_router),  32'(m_to_router));
         chk("self_send",  32'(self_send),  32'(m_self));
         chk("send_ready", 32'(send_ready), (exp_q.size() < FIFO_DEPTH) ? 32'd1 : 32'd0);
         chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
         chk("tx_busy",    32'(tx_busy),
             (exp_q.size() > 0 || (cyc >= m_last_inj && cyc <= m_last_inj + INJ_GAP)) ? 32'd1 : 32'd0);
         chk("tx_count",   32'(tx_count),   32'(m_tx));
         chk("rx_count",   32'(rx_count),   32'(m_rx));
         chk("drop_count", 32'(drop_count), 32'(m_drop));
         chk("rx_pulse",   32'(rx_pulse),   32'(m_rx_pulse));
         if (to_router[N2-1]) inj_log.push_back(cyc);
      end
      while (dq.size() > 0) begin
         dchk_t d;
         d = dq.pop_front();
         chk(d.nm, d.act, d.exp);
      end
   end

   // driver tasks
   task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
      dchk_t d;
      d.nm  = nm;
      d.act = act;
      d.exp = exp;
      dq.push_back(d);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; send_valid = 1'b0; from_router_data = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;
   endtask

   task automatic at_cycle(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   // one-cycle request at the next cycle; returns its cycle number
   task automatic send_one(input logic [K-1:0] d, output int t0);
      @(posedge clk); #1;
      t0 = cyc;
      send_valid = 1'b1;
      send_dest  = d;
      @(posedge clk); #1;
      send_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx_busy && n < 200);
      if (n >= 200) post(nm, 32'd1, 32'd0);
   endtask

   int t0;
   int t1;
   int base;
   int maxlvl;
   int guard;
   bit acc;
   logic [K-1:0] burst [6];
   int inj_exp [6];

   initial begin
      burst   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
      inj_exp = '{2, 8, 14, 20, 26, 32};

      // reset then idle
      router_name = 3'd0;
      do_reset();
      repeat (10) @(negedge clk);
      post("idle_to_router",  32'(to_router),  32'd0);
      post("idle_send_ready", 32'(send_ready), 32'd1);
      post("idle_tx_busy",    32'(tx_busy),    32'd0);
      post("idle_counters",   32'(tx_count) | 32'(rx_count) | 32'(drop_count), 32'd0);

      // single send, dest 3
      send_one(3'd3, t0);
      at_cycle(t0 + 1);
      post("single_c1_idle", 32'(to_router), 32'd0);
      at_cycle(t0 + 2);
      post("single_c2_word", 32'(to_router), 32'b1000011);
      at_cycle(t0 + 3);
      post("single_c3_idle", 32'(to_router), 32'd0);
      post("single_tx_count", 32'(tx_count), 32'd1);
      at_cycle(t0 + 2 + INJ_GAP);
      post("single_busy_gap_end", 32'(tx_busy), 32'd1);
      at_cycle(t0 + 3 + INJ_GAP);
      post("single_busy_clear", 32'(tx_busy), 32'd0);

      // held-valid burst of six requests
      do_reset();
      base   = inj_log.size();
      maxlvl = 0;
      @(posedge clk); #1;
      t0 = cyc;
      for (int i = 0; i < 6; i++) begin
         send_valid = 1'b1;
         send_dest  = burst[i];
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 50) begin
            @(negedge clk);
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
            acc = send_ready;
            @(posedge clk); #1;
            guard++;
         end
         if (!acc) post("burst_accept_timeout", 32'd1, 32'd0);
      end
      send_valid = 1'b0;
      wait_idle("burst_idle_timeout");
      post("burst_max_level", 32'(maxlvl), 32'd4);
      post("burst_inj_count", 32'(inj_log.size() - base), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (base + i < inj_log.size())
            post("burst_inj_cycle", 32'(inj_log[base + i] - t0), 32'(inj_exp[i]));
      end
      post("burst_tx_count", 32'(tx_count), 32'd6);

      // invalid destinations are dropped
      do_reset();
      base = inj_log.size();
      @(posedge clk); #1;
      send_valid = 1'b1; send_dest = 3'd6;
      @(posedge clk); #1;
      send_dest = 3'd7;
      @(posedge clk); #1;
      send_valid = 1'b0;
      repeat (10) @(negedge clk);
      post("drop_count", 32'(drop_count), 32'd2);
      post("drop_level", 32'(fifo_level), 32'd0);
      post("drop_no_inj", 32'(inj_log.size() - base), 32'd0);

      // self-send
      router_name = 3'd2;
      do_reset();
      send_one(3'd2, t0);
      at_cycle(t0 + 2);
      post("self_word", 32'(to_router), 32'b1000010);
      post("self_flag", 32'(self_send), 32'd1);
      at_cycle(t0 + 3);
      post("self_flag_clear", 32'(self_send), 32'd0);
      wait_idle("self_idle_timeout");

      // 300 back-to-back receive pulses with one concurrent injection
      router_name = 3'd0;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (i == 0) t0 = cyc;
         from_router_data = 1'b1;
         send_valid = (i == 0);
         send_dest  = 3'd1;
         if (i == 3) begin
            @(negedge clk);
            post("rxtx_tx_count", 32'(tx_count), 32'd1);
            post("rxtx_rx_count", 32'(rx_count), 32'd3);
         end
         if (i == 10) begin
            @(negedge clk);
            post("rx_count_10", 32'(rx_count), 32'd10);
            post("rx_pulse_on", 32'(rx_pulse), 32'd1);
         end
      end
      @(posedge clk); #1;
      from_router_data = 1'b0;
      @(negedge clk);
      post("rx_pulse_tail", 32'(rx_pulse), 32'd1);
      post("rx_saturated", 32'(rx_count), 32'd255);
      @(negedge clk);
      post("rx_pulse_off", 32'(rx_pulse), 32'd0);

      // reset during GAP with three entries queued
      do_reset();
      @(posedge clk); #1;
      t0 = cyc;
      for (int i = 0; i < 4; i++) begin
         send_valid = 1'b1;
         send_dest  = burst[i];
         @(posedge clk); #1;
      end
      send_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      post("pre_rst_level", 32'(fifo_level), 32'd3);
      post("pre_rst_tx_count", 32'(tx_count), 32'd1);
      post("pre_rst_busy", 32'(tx_busy), 32'd1);
      @(negedge clk);
      post("rst_to_router", 32'(to_router), 32'd0);
      post("rst_level", 32'(fifo_level), 32'd0);
      post("rst_tx_count", 32'(tx_count), 32'd0);
      post("rst_ready", 32'(send_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      send_one(3'd3, t1);
      at_cycle(t1 + 1);
      post("post_rst_c1", 32'(to_router), 32'd0);
      at_cycle(t1 + 2);
      post("post_rst_word", 32'(to_router), 32'b1000011);
      wait_idle("post_rst_idle_timeout");

      @(negedge clk);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
